au_mul_seq: RTL and testbench
=============================

Name: au_mul_seq

Overview:
- Sequential shift-add multiplier that sits directly upstream of the 16-bit add/subtract arithmetic unit (AU).
- Drives the AU operand/select inputs once per cycle and consumes the AU sum and zero flag to accumulate a truncated (low WIDTH bits) unsigned product.
- Gives the datapath a multiply op with a start/busy/done handshake without adding a second adder.

Parameters:
WIDTH, 16, operand/result width; must match the AU width (16)
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op_a  input  WIDTH  multiplicand, captured on accepted start
op_b  input  WIDTH  multiplier, captured on accepted start
busy  output  1  high in RUN
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  low WIDTH bits of op_a*op_b, held until next accepted start
zero  output  1  result==0, held with result
au_a  output  WIDTH  to AU A input
au_b  output  WIDTH  to AU B input
au_sel  output  2  to AU sel input; always 2'b00 (add)
au_x  input  WIDTH  AU sum
au_z  input  1  AU zero flag

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, result=0, zero=0; internal acc/mcand/mplier/cnt=0.
- Outputs au_a/au_b/au_sel are combinational from state. In IDLE/DONE all three are 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0, ->RUN.
  - start=0: stay.
- RUN, each cycle:
  - au_a=acc; au_b=mplier[0] ? mcand : 0; au_sel=2'b00.
  - At the edge: acc<=au_x; mcand<=mcand<<1 (bits shifted out are dropped); mplier<=mplier>>1; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: result<=au_x, zero<=au_z, ->DONE.
- DONE: done=1 for exactly one cycle, then ->IDLE. start in DONE is ignored, not queued.
- busy=1 exactly while state==RUN; done and busy are never both high.
- Latency (feature off): start accepted at edge 0; RUN during edges 1..16; done high between edges 16 and 17. Exactly WIDTH RUN cycles regardless of operands.
- Arithmetic: modulo 2^WIDTH; overflow silently truncated; no carry/overflow flag (the AU provides none).
- start while busy or in DONE: ignored; op_a/op_b changes after capture have no effect.
- result/zero change only on RUN->DONE (and reset); stable in IDLE.
- Reset mid-RUN: immediate abort to IDLE, result=0, zero=0, no done pulse.
- au_z is trusted as the zero flag of the final sum; the block does not recompute it.

Optional Feature:
- Macro AU_MUL_SEQ_EARLY_TERM_EN.
- Defined: in RUN, if mplier==0 at the start of a cycle, no add is issued that cycle (au_a/au_b/au_sel=0). At the edge: result<=acc, zero<=(acc==0), ->DONE.
  - Resulting latency = (index of highest set bit of op_b)+2 RUN cycles, capped at WIDTH.
  - op_b=0 finishes after 1 RUN cycle.
- Not defined: fixed WIDTH-cycle RUN as above; the mplier==0 check is not synthesised.
- Results are identical in both builds; only latency differs.

Test Plan:
- Reset release, no start -> busy=0, done=0, result=0x0000, zero=0; au_a/au_b/au_sel=0.
- op_a=0x0003, op_b=0x0005, start 1 cycle -> busy 16 cycles, done pulse at edge 16, result=0x000F, zero=0; au_sel=00 throughout.
- op_a=0x0100, op_b=0x0100 -> result=0x0000 (truncation), zero=1, done after 16 RUN cycles.
- op_a=0xFFFF, op_b=0xFFFF -> result=0x0001, zero=0; start pulsed at RUN cycle 5 and in DONE is ignored, with exactly one done pulse.
- Start op_a=0x1234, op_b=0x0002, assert rst at RUN cycle 7 -> busy/done/result/zero=0 immediately. A new start with 0x0002*0x0003 -> result=0x0006.
- With AU_MUL_SEQ_EARLY_TERM_EN: op_b=0x0000 -> done after 1 RUN cycle, result=0, zero=1. op_a=0x0007, op_b=0x0003 -> 3 RUN cycles, result=0x0015. Without the macro, the same stimulus takes 16 cycles with identical results.

Source files
------------

// File: rtl/au_mul_seq.sv
// Sequential shift-add multiplier that borrows the external 16-bit AU adder, one add per cycle.
// Optional macro AU_MUL_SEQ_EARLY_TERM_EN ends the run as soon as the remaining multiplier is zero.
module au_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic [1:0]       au_sel,
  input  logic [WIDTH-1:0] au_x,
  input  logic             au_z
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0] cnt;
  logic             early_stop;

  // With no multiplier bits left the accumulator already holds the final product.
`ifdef AU_MUL_SEQ_EARLY_TERM_EN
  assign early_stop = (state == RUN) && (mplier == '0);
`else
  assign early_stop = 1'b0;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    au_a       = '0;
    au_b       = '0;
    au_sel     = 2'b00;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        if (early_stop) begin
          next_state = DONE;
        end else begin
          au_a = acc;
          au_b = mplier[0] ? mcand : '0;
          if (cnt == LAST) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The AU sum becomes the new partial product; result/zero only move on the final RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (early_stop) begin
            result <= acc;
            zero   <= (acc == '0);
          end else begin
            acc    <= au_x;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              result <= au_x;
              zero   <= au_z;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_au_mul_seq.sv
// Self-checking bench for au_mul_seq: an ideal AU adder, an arithmetic product model and directed plus random runs.
module tb_au_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        busy, done, zero;
  logic [15:0] result, au_a, au_b, au_x;
  logic [1:0]  au_sel;
  logic        au_z;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference state: operands, RUN cycles elapsed and expected run length.
  bit          m_busy, m_done, m_zero;
  logic [31:0] m_a, m_b, m_result;
  int          m_k, m_len;

  au_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .au_a(au_a), .au_b(au_b), .au_sel(au_sel), .au_x(au_x), .au_z(au_z)
  );

  assign au_x = au_a + au_b;
  assign au_z = (au_x == 16'h0000);

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] b);
`ifdef AU_MUL_SEQ_EARLY_TERM_EN
    if (b == 16'h0000) return 1;
    for (int i = 15; i >= 0; i--)
      if (b[i]) return (i + 2 > 16) ? 16 : i + 2;
    return 16;
`else
    return 16;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_zero = 0; m_result = 0;
      m_a = 0; m_b = 0; m_k = 0; m_len = 0;
    end else if (m_busy) begin
      m_k++;
      if (m_k == m_len) begin
        m_busy   = 0;
        m_done   = 1;
        m_result = (m_a * m_b) & 32'hFFFF;
        m_zero   = (m_result == 0);
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      m_a = {16'h0, op_a}; m_b = {16'h0, op_b};
      m_k = 0; m_len = exp_lat(op_b); m_busy = 1;
    end
  end

  // Every cycle: handshake, held result and the exact AU operands implied by the partial product.
  always @(negedge clk) begin
    logic [31:0] exp_a, exp_b;
    bit idle_add;
    if (chk_en && !rst) begin
      check("busy", {31'h0, busy}, {31'h0, m_busy});
      check("done", {31'h0, done}, {31'h0, m_done});
      check("result", {16'h0, result}, m_result);
      check("zero", {31'h0, zero}, {31'h0, m_zero});
      check("au_sel", {30'h0, au_sel}, 32'h0);
      exp_a = 0; exp_b = 0;
      if (m_busy) begin
`ifdef AU_MUL_SEQ_EARLY_TERM_EN
        idle_add = ((m_b >> m_k) == 0);
`else
        idle_add = 0;
`endif
        if (!idle_add) begin
          exp_a = (m_a * (m_b & ((32'h1 << m_k) - 1))) & 32'hFFFF;
          exp_b = m_b[m_k] ? ((m_a << m_k) & 32'hFFFF) : 32'h0;
        end
      end
      check("au_a", {16'h0, au_a}, exp_a);
      check("au_b", {16'h0, au_b}, exp_b);
    end
  end

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_r,
                         input bit exp_z, input int exp_cyc, input bit poke);
    int cyc = 0;
    int guard = 0;
    int extra = 0;
    @(posedge clk); #1;
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (busy) cyc++;
      guard++;
      if (guard > 100) begin
        check("done_timeout", 32'h0, 32'h1);
        break;
      end
      if (poke) begin
        start = (cyc == 5);
        op_a = 16'($urandom); op_b = 16'($urandom);
      end
    end
    check("run_cycles", cyc, exp_cyc);
    check("lit_result", {16'h0, result}, {16'h0, exp_r});
    check("lit_zero", {31'h0, zero}, {31'h0, exp_z});
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("single_done", extra, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb, rp;
    int n;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_result", {16'h0, result}, 32'h0);
    check("rst_zero", {31'h0, zero}, 32'h0);
    check("rst_au", {14'h0, au_sel, au_a ^ au_b}, 32'h0);

    run_mul(16'h0003, 16'h0005, 16'h000F, 1'b0, exp_lat(16'h0005), 1'b0);
    run_mul(16'h0100, 16'h0100, 16'h0000, 1'b1, exp_lat(16'h0100), 1'b0);
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 16, 1'b1);
    run_mul(16'h0007, 16'h0003, 16'h0015, 1'b0, exp_lat(16'h0003), 1'b0);
    run_mul(16'h1234, 16'h0000, 16'h0000, 1'b1, exp_lat(16'h0000), 1'b0);
`ifdef AU_MUL_SEQ_EARLY_TERM_EN
    check("lat_b3", exp_lat(16'h0003), 3);
    check("lat_b0", exp_lat(16'h0000), 1);
`else
    check("lat_b3", exp_lat(16'h0003), 16);
    check("lat_b0", exp_lat(16'h0000), 16);
`endif

    // Reset in the middle of a run aborts with cleared outputs.
    @(posedge clk); #1;
    op_a = 16'h1234; op_b = 16'h0002; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < ((exp_lat(16'h0002) > 7) ? 7 : exp_lat(16'h0002) - 1)) begin
      @(negedge clk);
      if (busy) n++;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_result", {16'h0, result}, 32'h0);
    check("abort_zero", {31'h0, zero}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_mul(16'h0002, 16'h0003, 16'h0006, 1'b0, exp_lat(16'h0003), 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 16);
      rp = 16'(32'(ra) * 32'(rb));
      run_mul(ra, rb, rp, (rp == 16'h0000), exp_lat(rb), (i % 4) == 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
